adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational adder datapath among N_REQ requesters (the AXI register-file controller plus auxiliary engines). It accepts operand/op requests, grants one at a time, drives the datapath from registered operands, and captures the result. The result is returned to the winning requester over a valid/ready handshake. It sits between the requesters and the datapath, replacing direct register-to-datapath wiring.

---
 rtl/adder_arbiter.sv | 153 +++++++++++++++
 tb/tb_adder_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter and sequencer that shares one combinational
// adder/subtractor datapath among N_REQ requesters. It grants one request at a
// time, drives the datapath from registered operands, captures the result and
// holds it on a one-hot valid/ready handshake back to the winner.
// Optional feature: define ADDER_ARB_OVF_EN to add the registered o_ovf output
// (signed overflow of o_result).
module adder_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARST,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ-1:0]            i_op,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_busa,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_busb,
  output logic [N_REQ-1:0]            o_gnt,
  output logic [N_REQ-1:0]            o_valid,
  input  logic [N_REQ-1:0]            i_ready,
  output logic [DATA_WIDTH-1:0]       o_result,
  output logic [DATA_WIDTH-1:0]       o_dp_busa,
  output logic [DATA_WIDTH-1:0]       o_dp_busb,
  output logic                        o_dp_op,
  input  logic [DATA_WIDTH-1:0]       i_dp_busr,
  output logic                        o_busy
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                        o_ovf
`endif
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t              state;
  logic [PW-1:0]       ptr;

  logic [DATA_WIDTH-1:0] opa [N_REQ];
  logic [DATA_WIDTH-1:0] opb [N_REQ];

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       win_next_ptr;
  logic [N_REQ-1:0]    win_onehot;
  logic [PW:0]         scan_sum;
  logic [PW:0]         next_sum;

  // Split the packed operand buses into per-requester slices.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign opa[g] = i_busa[g*DATA_WIDTH +: DATA_WIDTH];
    assign opb[g] = i_busb[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan upward from ptr with wrap, first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PW+1)'(N_REQ);
      end
      if (!win_found && i_req[scan_sum[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[PW-1:0];
      end
    end
  end

  // Next pointer is the index just after the winner, plus the one-hot grant.
  always_comb begin
    next_sum = {1'b0, win_idx} + (PW+1)'(1);
    if (next_sum >= (PW+1)'(N_REQ)) begin
      next_sum = '0;
    end
    win_next_ptr        = next_sum[PW-1:0];
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_next;

  // Signed overflow: result sign differs from a, and the operand signs make
  // overflow possible (same sign for add, different sign for sub).
  always_comb begin
    ovf_next = (i_dp_busr[MSB] ^ o_dp_busa[MSB]) &
               (o_dp_op ? (o_dp_busa[MSB] ^ o_dp_busb[MSB])
                        : ~(o_dp_busa[MSB] ^ o_dp_busb[MSB]));
  end
`endif

  // Sequencer: IDLE grants and latches operands, EXEC captures the datapath
  // result, RESP holds it until the winner accepts.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state     <= IDLE;
      ptr       <= '0;
      o_gnt     <= '0;
      o_valid   <= '0;
      o_result  <= '0;
      o_dp_busa <= '0;
      o_dp_busb <= '0;
      o_dp_op   <= 1'b0;
      o_busy    <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      o_ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            o_dp_busa <= opa[win_idx];
            o_dp_busb <= opb[win_idx];
            o_dp_op   <= i_op[win_idx];
            o_gnt     <= win_onehot;
            ptr       <= win_next_ptr;
            o_busy    <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // The grant vector is exactly the one-hot valid for the winner.
          o_result <= i_dp_busr;
          o_valid  <= o_gnt;
          o_gnt    <= '0;
`ifdef ADDER_ARB_OVF_EN
          o_ovf    <= ovf_next;
`endif
          state    <= RESP;
        end
        RESP: begin
          if (|(i_ready & o_valid)) begin
            o_valid <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against a
// transaction-level reference model (pending-request set, round-robin pointer,
// plain arithmetic results).
`timescale 1ns/1ps
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           ACLK = 1'b0;
  logic           ARST;
  logic [N-1:0]   i_req, i_op, i_ready, o_gnt, o_valid;
  logic [N*W-1:0] i_busa, i_busb;
  logic [W-1:0]   o_result, o_dp_busa, o_dp_busb, i_dp_busr;
  logic           o_dp_op, o_busy;
`ifdef ADDER_ARB_OVF_EN
  logic           o_ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] pend;
  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  logic         mop [N];
  int           mptr;

  always #5 ACLK = ~ACLK;

  // Combinational datapath the arbiter is meant to drive
  assign i_dp_busr = o_dp_op ? (o_dp_busa - o_dp_busb) : (o_dp_busa + o_dp_busb);

  adder_arbiter #(.N_REQ(N), .DATA_WIDTH(W)) dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .i_req     (i_req),
    .i_op      (i_op),
    .i_busa    (i_busa),
    .i_busb    (i_busb),
    .o_gnt     (o_gnt),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_dp_busa (o_dp_busa),
    .o_dp_busb (o_dp_busb),
    .o_dp_op   (o_dp_op),
    .i_dp_busr (i_dp_busr),
    .o_busy    (o_busy)
`ifdef ADDER_ARB_OVF_EN
    ,
    .o_ovf     (o_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = op ? (sa - sb) : (sa + sb);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return '1;
      default: return $urandom;
    endcase
  endfunction

  // Winner: first pending index at or after the round-robin pointer
  function automatic int pick();
    for (int off = 0; off < N; off++) begin
      if (pend[(mptr + off) % N]) return (mptr + off) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    i_req = pend;
    for (int k = 0; k < N; k++) begin
      i_busa[k*W +: W] = ma[k];
      i_busb[k*W +: W] = mb[k];
      i_op[k]          = mop[k];
    end
  endtask

  task automatic add_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    pend[k] = 1'b1;
    ma[k]   = a;
    mb[k]   = b;
    mop[k]  = op;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    o_gnt, 0);
    chk({tag, "_valid"},  o_valid, 0);
    chk({tag, "_result"}, o_result, 0);
    chk({tag, "_dpa"},    o_dp_busa, 0);
    chk({tag, "_dpb"},    o_dp_busb, 0);
    chk({tag, "_dpop"},   o_dp_op, 0);
    chk({tag, "_busy"},   o_busy, 0);
`ifdef ADDER_ARB_OVF_EN
    chk({tag, "_ovf"},    o_ovf, 0);
`endif
  endtask

  // Called at a negedge with requests already driven while the DUT is idle.
  task automatic serve(input int dly);
    int k;
    logic [N-1:0] oh;
    logic [W-1:0] a, b, r;
    logic op;
    k = pick();
    if (k < 0) return;
    a = ma[k]; b = mb[k]; op = mop[k];
    r = op ? (a - b) : (a + b);
    oh = '0;
    oh[k] = 1'b1;
    @(negedge ACLK);
    chk("gnt", o_gnt, oh);
    chk("busy_exec", o_busy, 1);
    chk("valid_exec", o_valid, 0);
    chk("dp_busa", o_dp_busa, a);
    chk("dp_busb", o_dp_busb, b);
    chk("dp_op", o_dp_op, op);
    pend[k] = 1'b0;
    mptr = (k + 1) % N;
    i_req = pend;
    @(negedge ACLK);
    chk("valid", o_valid, oh);
    chk("result", o_result, r);
    chk("gnt_drop", o_gnt, 0);
`ifdef ADDER_ARB_OVF_EN
    chk("ovf", o_ovf, ovf_ref(a, b, op));
`endif
    for (int d = 0; d < dly; d++) begin
      i_ready = (d == 0) ? (4'b0010 & ~oh) : (N'($urandom) & ~oh);
      @(negedge ACLK);
      chk("valid_hold", o_valid, oh);
      chk("result_hold", o_result, r);
      chk("busy_resp", o_busy, 1);
      chk("gnt_resp", o_gnt, 0);
    end
    i_ready = oh | (N'($urandom) & ~oh);
    @(negedge ACLK);
    chk("valid_clear", o_valid, 0);
    chk("busy_idle", o_busy, 0);
    chk("gnt_idle", o_gnt, 0);
    i_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARST = 1'b1;
    pend = '0;
    drive_reqs();
    i_ready = '0;
    @(negedge ACLK);
    chk_all_zero("reset");
    ARST = 1'b0;
    mptr = 0;
  endtask

  initial begin
    ARST    = 1'b1;
    i_ready = '0;
    pend    = '0;
    mptr    = 0;
    for (int k = 0; k < N; k++) begin
      ma[k] = '0; mb[k] = '0; mop[k] = 1'b0;
    end
    drive_reqs();
    repeat (2) @(negedge ACLK);
    chk_all_zero("por");
    ARST = 1'b0;

    // Single add on requester 0
    add_req(0, 32'd5, 32'd7, 1'b0);
    drive_reqs();
    serve(0);
    chk("t1_result", o_result, 32'd12);

    // Idle with no requests: everything holds
    repeat (2) @(negedge ACLK);
    chk("idle_busy", o_busy, 0);
    chk("idle_gnt", o_gnt, 0);
    chk("idle_dpa", o_dp_busa, 32'd5);
    chk("idle_result", o_result, 32'd12);

    // All four from reset (pointer was 1 before reset): order 0,1,2,3
    do_reset();
    for (int k = 0; k < N; k++) add_req(k, rnd_op(), rnd_op(), 1'($urandom));
    drive_reqs();
    for (int k = 0; k < N; k++) serve(0);

    // Subtract held in RESP for 5 cycles with a stray i_ready[1]
    add_req(2, 32'd3, 32'd10, 1'b1);
    drive_reqs();
    serve(5);
    chk("t3_result", o_result, 32'hFFFF_FFF9);

    // Reset during EXEC aborts the operation
    add_req(1, 32'd100, 32'd1, 1'b0);
    drive_reqs();
    @(negedge ACLK);
    chk("abort_gnt", o_gnt, 4'b0010);
    #2 ARST = 1'b1;
    #1 chk_all_zero("abort_async");
    pend = '0;
    drive_reqs();
    @(negedge ACLK);
    chk("abort_novalid", o_valid, 0);
    ARST = 1'b0;
    mptr = 0;
    @(negedge ACLK);
    chk("abort_after_valid", o_valid, 0);
    add_req(3, 32'h1234_5678, 32'h1111_1111, 1'b1);
    drive_reqs();
    serve(1);

`ifdef ADDER_ARB_OVF_EN
    add_req(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    drive_reqs();
    serve(0);
    chk("ovf_add_result", o_result, 32'h8000_0000);
    chk("ovf_add", o_ovf, 1);
    add_req(1, 32'h8000_0000, 32'd1, 1'b1);
    drive_reqs();
    serve(0);
    chk("ovf_sub", o_ovf, 1);
    add_req(2, 32'd2, 32'd1, 1'b1);
    drive_reqs();
    serve(0);
    chk("ovf_sub_none", o_ovf, 0);
`endif

    // Randomized rounds with overlapping pending requests
    for (int round = 0; round < 60; round++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) add_req(k, rnd_op(), rnd_op(), 1'($urandom));
      end
      if (pend == '0) add_req($urandom_range(0, N-1), rnd_op(), rnd_op(), 1'($urandom));
      drive_reqs();
      serve($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
